// File: rtl/riscv_core_irq_pkg.sv
// Shared types and constants for the machine external interrupt arbiter.
package riscv_core_irq_pkg;

  localparam int IRQ_NUM_SRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/riscv_core_irq_prio_sel.sv
// Combinational winner selection over the candidate set.
// The search starts at rr_ptr_i+1 (mod NUM_SRC). Tying rr_ptr_i to NUM_SRC-1
// makes the search start at index 0, which gives lowest-index-wins priority.
module riscv_core_irq_prio_sel #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] candidate_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [ID_W-1:0]    winner_id_o,
  output logic               valid_o
);

  localparam int unsigned N = NUM_SRC;

  // Scan every source once, starting just after rr_ptr_i; first hit wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    winner_id_o = '0;
    valid_o     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_i) + 32'd1 + k;
      if (idx >= N) idx = idx - N;
      if (!valid_o && candidate_i[idx[ID_W-1:0]]) begin
        valid_o     = 1'b1;
        winner_id_o = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/riscv_core_irq_arbiter.sv
// Machine external interrupt arbiter: edge gateway, pending/mask registers,
// claim/complete handshake FSM feeding mip.MEIP.
// Optional feature: define RISCV_CORE_IRQ_RR_EN for round-robin selection;
// otherwise the lowest pending+enabled index wins.
module riscv_core_irq_arbiter
  import riscv_core_irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEFAULT,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst_n,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_src,
  input  logic               i_riscv_core_irq_cfg_wen,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_cfg_wdata,
  input  logic               i_riscv_core_ack,
  input  logic               i_riscv_core_irq_complete,
  output logic               o_riscv_core_mexternal,
  output logic [ID_W-1:0]    o_riscv_core_irq_id,
  output logic               o_riscv_core_irq_busy,
  output logic [NUM_SRC-1:0] o_riscv_core_irq_pending,
  output logic [NUM_SRC-1:0] o_riscv_core_irq_mask
);

  logic [NUM_SRC-1:0] src_q;
  logic               armed_q;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] candidate;
  irq_state_e         state_q;
  logic [ID_W-1:0]    irq_id_q;
  logic               mexternal_q;
  logic               busy_q;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;
  logic [ID_W-1:0]    rr_ptr;
  logic               claim;

`ifdef RISCV_CORE_IRQ_RR_EN
  logic [ID_W-1:0]    rr_ptr_q;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = ID_W'(NUM_SRC - 1);
`endif

  // Gateway: src_q resets to 0, so armed_q suppresses edge detection on the
  // first edge after reset; lines held high through release give no event.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      src_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      src_q   <= i_riscv_core_irq_src;
      armed_q <= 1'b1;
    end
  end

  assign src_rise  = armed_q ? (i_riscv_core_irq_src & ~src_q) : '0;
  assign claim     = (state_q == IRQ_REQ) && i_riscv_core_ack;
  assign candidate = pending_q & mask_q;

  // Pending next state: claim clears the served bit, a new edge sets it (set wins).
  always_comb begin
    pending_d = pending_q;
    if (claim) pending_d[irq_id_q] = 1'b0;
    pending_d = pending_d | src_rise;
  end

  // Pending and enable-mask registers.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (i_riscv_core_irq_cfg_wen) mask_q <= i_riscv_core_irq_cfg_wdata;
    end
  end

  riscv_core_irq_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_sel (
    .candidate_i (candidate),
    .rr_ptr_i    (rr_ptr),
    .winner_id_o (sel_id),
    .valid_o     (sel_valid)
  );

  // Request/claim/complete handshake with registered mexternal and busy.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      state_q     <= IRQ_IDLE;
      irq_id_q    <= '0;
      mexternal_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RISCV_CORE_IRQ_RR_EN
      rr_ptr_q    <= ID_W'(NUM_SRC - 1);
`endif
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (sel_valid) begin
            irq_id_q    <= sel_id;
            state_q     <= IRQ_REQ;
            mexternal_q <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (i_riscv_core_ack) begin
            state_q     <= IRQ_SERVICE;
            mexternal_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef RISCV_CORE_IRQ_RR_EN
            rr_ptr_q    <= irq_id_q;
`endif
          end else if (!candidate[irq_id_q]) begin
            state_q     <= IRQ_IDLE;
            mexternal_q <= 1'b0;
          end
        end
        IRQ_SERVICE: begin
          if (i_riscv_core_irq_complete) begin
            state_q <= IRQ_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IRQ_IDLE;
          mexternal_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_riscv_core_mexternal   = mexternal_q;
  assign o_riscv_core_irq_id      = irq_id_q;
  assign o_riscv_core_irq_busy    = busy_q;
  assign o_riscv_core_irq_pending = pending_q;
  assign o_riscv_core_irq_mask    = mask_q;

endmodule

// File: doc/riscv_core_irq_arbiter.md
RISCV_CORE_IRQ_ARBITER -- requirements
Module: riscv_core_irq_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 8: number of external interrupt sources, legal range 2..32.
REQ-002 Parameter ID_W, default $clog2(NUM_SRC): width of the source ID.
REQ-003 i_riscv_core_clk  in  1  clock; all state updates on its rising edge.
REQ-004 i_riscv_core_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_riscv_core_irq_src  in  NUM_SRC  raw level interrupt lines; a rising edge marks one event.
REQ-006 i_riscv_core_irq_cfg_wen  in  1  writes the enable mask.
REQ-007 i_riscv_core_irq_cfg_wdata  in  NUM_SRC  new enable mask.
REQ-008 i_riscv_core_ack  in  1  claim acknowledge from the CSR unit's trap-entry FSM.
REQ-009 i_riscv_core_irq_complete  in  1  one-cycle handler-done pulse, driven by mret retirement.
REQ-010 o_riscv_core_mexternal  out  1  machine external interrupt request to the CSR unit (mip.MEIP source).
REQ-011 o_riscv_core_irq_id  out  ID_W  ID of the source currently requested or in service.
REQ-012 o_riscv_core_irq_busy  out  1  high while in IRQ_SERVICE.
REQ-013 o_riscv_core_irq_pending  out  NUM_SRC  pending vector, for readback.
REQ-014 o_riscv_core_irq_mask  out  NUM_SRC  current enable mask, for readback.

Function
REQ-015 The gateway SHALL register irq_src into src_q each cycle; at a clock edge where src=1 and src_q=0, pending[i] SHALL be set, independent of the mask.
REQ-016 The candidate set SHALL be pending & mask, using the registered mask value from before any same-cycle cfg write.
REQ-017 The FSM SHALL have three states: IRQ_IDLE, IRQ_REQ and IRQ_SERVICE.
REQ-018 In IRQ_IDLE with a non-empty candidate set, the FSM SHALL latch the winner into irq_id and move to IRQ_REQ on the next edge; if the set is empty it SHALL stay in IRQ_IDLE.
REQ-019 o_riscv_core_mexternal SHALL be registered and high exactly while the state is IRQ_REQ, so it rises one cycle after the winning pending bit is set.
REQ-020 In IRQ_REQ, i_riscv_core_ack=1 SHALL clear pending[irq_id] and move the FSM to IRQ_SERVICE.
REQ-021 In IRQ_REQ, if candidate[irq_id] drops to 0 (masked off) without an ack, the FSM SHALL return to IRQ_IDLE and retract the request.
REQ-022 In IRQ_SERVICE, i_riscv_core_irq_complete=1 SHALL return the FSM to IRQ_IDLE; no new request SHALL be raised during IRQ_SERVICE (no nesting).
REQ-023 i_riscv_core_ack outside IRQ_REQ and i_riscv_core_irq_complete outside IRQ_SERVICE SHALL be ignored.
REQ-024 If a new rising edge on source irq_id coincides with its claim-clear, the set SHALL win and pending SHALL remain 1.
REQ-025 A cfg write SHALL update the mask on the next edge; it SHALL NOT alter pending bits.
REQ-026 Fixed priority, used when round robin is disabled: the lowest index wins.
REQ-027 o_riscv_core_irq_id SHALL hold its value through IRQ_REQ and IRQ_SERVICE, and until the next selection.

Reset
REQ-028 On reset assertion, at any time including mid-handshake: state=IRQ_IDLE, pending=0, mask=0, src_q=0, irq_id=0, mexternal=0, busy=0, rr_ptr=NUM_SRC-1.
REQ-029 Sources held high through reset release SHALL produce no event until they fall and rise again.

Configuration
REQ-030 With macro RISCV_CORE_IRQ_RR_EN defined, selection SHALL be round robin: the search starts at rr_ptr+1 modulo NUM_SRC, and rr_ptr is updated to irq_id on each ack.
REQ-031 Without RISCV_CORE_IRQ_RR_EN, rr_ptr SHALL NOT exist and selection SHALL follow REQ-026.

Structure
REQ-032 Package riscv_core_irq_pkg SHALL hold the irq_state_e enum typedef (IRQ_IDLE, IRQ_REQ, IRQ_SERVICE) and the constant IRQ_NUM_SRC_DEFAULT=8.
REQ-033 Winner selection SHALL be a combinational sub-module riscv_core_irq_prio_sel with inputs candidate and rr_ptr and outputs winner ID and valid; all state stays in the top module.

Verification
REQ-034 Mask=8'hFF, rising edge on src[3] at edge k -> pending=8'h08 after edge k; mexternal=1 and irq_id=3 after edge k+1.
REQ-035 In IRQ_REQ with id 3, ack pulse -> pending=0, busy=1, mexternal=0; complete pulse -> IRQ_IDLE, busy=0.
REQ-036 Fixed build, src[5] and src[2] rise together -> id 2 is served first, then id 5 after complete.
REQ-037 RR build, src[0] and src[1] re-raised after every complete -> grant order 0,1,0,1.
REQ-038 Mask=8'h10, src[4] rises and mexternal=1; write mask=0 before ack -> mexternal drops the next cycle and pending[4] stays 1; re-enable -> request re-raised.
REQ-039 Assert reset during IRQ_SERVICE with pending=8'h81 -> all outputs 0 immediately; holding src high after release -> no request.
